// File: rtl/key_schedule_reverse_if.sv
// Request and round-key stream bundle for the AES-192 reverse key scheduler.
// master = key consumer and start requester, slave = key_schedule_reverse.
interface key_schedule_reverse_if;
    logic         start;
    logic [191:0] user_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_out;
    logic [3:0]   key_idx;
    logic         key_last;

    modport master (
        output start, user_key, key_ready,
        input  busy, key_valid, key_out, key_idx, key_last
    );

    modport slave (
        input  start, user_key, key_ready,
        output busy, key_valid, key_out, key_idx, key_last
    );
endinterface

// File: rtl/key_schedule_reverse.sv
// AES-192 decrypt key scheduler: runs the forward expansion, then walks it backwards and streams rk12..rk0.
// Optional macro KEY_INV_MIXCOL_EN: emit rk1..rk11 with InvMixColumns applied (equivalent inverse cipher keys).
module key_schedule_reverse (
    input  logic clk,
    input  logic rst,
    key_schedule_reverse_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FWD, INIT, OUT} state_t;

    state_t       state_reg;
    logic [191:0] grp_hi_reg;
    logic [191:0] grp_lo_reg;
    logic [3:0]   gl_reg;
    logic [3:0]   round_reg;
    logic [127:0] key_out_reg;
    logic [3:0]   key_idx_reg;
    logic         key_valid_reg;
    logic         key_last_reg;
    logic         busy_reg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (254 = 2+4+...+128), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h01;
        x = a;
        for (int i = 1; i < 8; i++) begin
            x = gf_mul(x, x);
            r = gf_mul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        logic [7:0] b;
        b = 8'h01 << (r - 4'd1);
        return {b, 24'h000000};
    endfunction

    function automatic logic [191:0] fwd_round(input logic [191:0] g, input logic [3:0] r);
        logic [31:0] n [6];
        n[0] = g[191:160] ^ sub_rot_word(g[31:0]) ^ rcon_word(r);
        for (int j = 1; j < 6; j++) n[j] = g[191-32*j -: 32] ^ n[j-1];
        return {n[0], n[1], n[2], n[3], n[4], n[5]};
    endfunction

    // Recovers G_(r-1) from G_r.
    function automatic logic [191:0] inv_step(input logic [191:0] c, input logic [3:0] r);
        logic [31:0] p [6];
        for (int j = 5; j >= 1; j--) p[j] = c[191-32*j -: 32] ^ c[191-32*(j-1) -: 32];
        p[0] = c[191:160] ^ sub_rot_word(p[5]) ^ rcon_word(r);
        return {p[0], p[1], p[2], p[3], p[4], p[5]};
    endfunction

    logic [191:0] inv_res;
    logic [191:0] sel_lo;
    logic [191:0] sel_hi;
    logic [3:0]   sel_gl;
    logic [3:0]   sel_idx;
    logic [5:0]   win_base;
    logic [5:0]   sel_off;
    logic [383:0] win_shift;
    logic [127:0] key_raw;
    logic [127:0] key_fmt;

    // One shared inverse step: builds G_7 in INIT, or the next lower group when the window slides down.
    assign inv_res  = inv_step((state_reg == INIT) ? grp_hi_reg : grp_lo_reg,
                               (state_reg == INIT) ? 4'd8 : gl_reg);
    assign win_base = {gl_reg, 2'b00} + {1'b0, gl_reg, 1'b0};

    always_comb begin
        sel_idx = key_idx_reg - 4'd1;
        sel_lo  = grp_lo_reg;
        sel_hi  = grp_hi_reg;
        sel_gl  = gl_reg;
        if (state_reg == INIT) begin
            sel_idx = 4'd12;
            sel_lo  = inv_res;
            sel_gl  = 4'd7;
        end else if ({sel_idx, 2'b00} < win_base) begin
            sel_hi = grp_lo_reg;
            sel_lo = inv_res;
            sel_gl = gl_reg - 4'd1;
        end
        sel_off   = {sel_idx, 2'b00} - ({sel_gl, 2'b00} + {1'b0, sel_gl, 1'b0});
        win_shift = {sel_lo, sel_hi} << {sel_off, 5'b00000};
        key_raw   = win_shift[383:256];
    end

`ifdef KEY_INV_MIXCOL_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    logic [127:0] key_mix;
    for (genvar gi = 0; gi < 4; gi++) begin : g_imc
        assign key_mix[127-32*gi -: 32] = inv_mix_col(key_raw[127-32*gi -: 32]);
    end
    // First and last keys stay raw; they are used for plain AddRoundKey.
    assign key_fmt = (sel_idx != 4'd0 && sel_idx != 4'd12) ? key_mix : key_raw;
`else
    assign key_fmt = key_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grp_hi_reg    <= '0;
            grp_lo_reg    <= '0;
            gl_reg        <= '0;
            round_reg     <= '0;
            key_out_reg   <= '0;
            key_idx_reg   <= '0;
            key_valid_reg <= 1'b0;
            key_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (bus.start) begin
                    grp_hi_reg <= bus.user_key;
                    round_reg  <= 4'd1;
                    busy_reg   <= 1'b1;
                    state_reg  <= FWD;
                end
                FWD: begin
                    grp_hi_reg <= fwd_round(grp_hi_reg, round_reg);
                    round_reg  <= round_reg + 4'd1;
                    if (round_reg == 4'd8) state_reg <= INIT;
                end
                INIT: begin
                    grp_lo_reg    <= sel_lo;
                    gl_reg        <= sel_gl;
                    key_out_reg   <= key_fmt;
                    key_idx_reg   <= sel_idx;
                    key_valid_reg <= 1'b1;
                    key_last_reg  <= 1'b0;
                    state_reg     <= OUT;
                end
                OUT: if (bus.key_ready) begin
                    if (key_idx_reg != 4'd0) begin
                        grp_lo_reg   <= sel_lo;
                        grp_hi_reg   <= sel_hi;
                        gl_reg       <= sel_gl;
                        key_out_reg  <= key_fmt;
                        key_idx_reg  <= sel_idx;
                        key_last_reg <= (sel_idx == 4'd0);
                    end else begin
                        key_valid_reg <= 1'b0;
                        key_last_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.key_valid = key_valid_reg;
    assign bus.key_out   = key_out_reg;
    assign bus.key_idx   = key_idx_reg;
    assign bus.key_last  = key_last_reg;
endmodule

// File: tb/tb_key_schedule_reverse.sv
// Bench for key_schedule_reverse: directed sequences with random keys and ready toggling,
// checked against a word-array model of the AES-192 expansion.
module tb_key_schedule_reverse;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_schedule_reverse_if bus();
    key_schedule_reverse dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_rk [13];
    logic [127:0] first_key;
    logic [127:0] last_key;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int bt = 15; bt >= 8; bt--) if (p[bt]) p = p ^ (16'h011b << (bt - 8));
        return p[7:0];
    endfunction

    // S-box straight from its definition: brute-force inverse, then bitwise affine transform.
    function automatic logic [7:0] sbox_m(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        c = 8'h63;
        for (int b = 1; b < 256; b++) if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] invmix_m(input logic [31:0] col);
        logic [31:0] coefs;
        logic [31:0] res;
        logic [7:0]  acc;
        coefs = 32'h0e0b0d09;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++)
                acc = acc ^ gmul(col[31-8*c -: 8], coefs[31-8*((c-r+4)%4) -: 8]);
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    task automatic build_model(input logic [191:0] key);
        logic [31:0]  w [52];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int k = 0; k < 13; k++) begin
            rk = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
`ifdef KEY_INV_MIXCOL_EN
            if (k >= 1 && k <= 11)
                rk = {invmix_m(rk[127:96]), invmix_m(rk[95:64]), invmix_m(rk[63:32]), invmix_m(rk[31:0])};
`endif
            exp_rk[k] = rk;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; 1: stall at idx 7 plus random ready; 2: stray starts; 3: reset at idx 6.
    task automatic run_seq(input logic [191:0] key, input int mode, input string name);
        int exp_idx;
        int stall;
        int guard;
        logic acc;
        build_model(key);
        bus.user_key = key;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({name, " busy_after_start"}, bus.busy, 1);
        chk({name, " valid_after_start"}, bus.key_valid, 0);
        for (int c = 1; c <= 8; c++) begin
            if (mode == 2 && c == 4) begin
                bus.start = 1'b1;
                bus.user_key = '0;
            end
            tick();
            bus.start = 1'b0;
            bus.user_key = key;
            chk({name, " valid_during_fwd"}, bus.key_valid, 0);
        end
        tick();
        exp_idx = 12;
        stall = 0;
        guard = 0;
        while (1) begin
            chk({name, " key_valid"}, bus.key_valid, 1);
            chk({name, " key_idx"}, bus.key_idx, 128'(exp_idx));
            chk({name, " key_out"}, bus.key_out, exp_rk[exp_idx]);
            chk({name, " key_last"}, bus.key_last, (exp_idx == 0) ? 1 : 0);
            chk({name, " busy_out"}, bus.busy, 1);
            if (exp_idx == 12) first_key = bus.key_out;
            if (exp_idx == 0) last_key = bus.key_out;
            if (mode == 3 && exp_idx == 6) begin
                #2 rst = 1'b1;
                #1;
                chk({name, " rst_valid"}, bus.key_valid, 0);
                chk({name, " rst_busy"}, bus.busy, 0);
                chk({name, " rst_key_out"}, bus.key_out, 0);
                chk({name, " rst_key_idx"}, bus.key_idx, 0);
                chk({name, " rst_key_last"}, bus.key_last, 0);
                #2 rst = 1'b0;
                $display("seq %s key=%h reset at idx 6", name, key);
                return;
            end
            acc = 1'b1;
            if (mode == 1) begin
                if (exp_idx == 7 && stall < 5) begin
                    acc = 1'b0;
                    stall++;
                end else if (exp_idx != 7) begin
                    acc = 1'($urandom_range(0, 1));
                end
            end
            if (mode == 2 && exp_idx == 3) begin
                bus.start = 1'b1;
                bus.user_key = '0;
            end
            bus.key_ready = acc;
            tick();
            bus.start = 1'b0;
            bus.user_key = key;
            bus.key_ready = 1'b0;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $error("FAIL %s timeout observed=%0d cycles expected<=100", name, guard);
                break;
            end
            if (acc) begin
                if (exp_idx == 0) break;
                exp_idx--;
            end
        end
        chk({name, " busy_after_rk0"}, bus.busy, 0);
        chk({name, " valid_after_rk0"}, bus.key_valid, 0);
        chk({name, " last_after_rk0"}, bus.key_last, 0);
        $display("seq %s key=%h mode=%0d cycles=%0d", name, key, mode, guard);
    endtask

    function automatic logic [191:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.user_key = '0;
        bus.key_ready = 1'b0;
        repeat (3) tick();
        chk("reset busy", bus.busy, 0);
        chk("reset valid", bus.key_valid, 0);
        chk("reset key_out", bus.key_out, 0);
        chk("reset key_idx", bus.key_idx, 0);
        chk("reset key_last", bus.key_last, 0);
        rst = 1'b0;
        tick();

        run_seq(KEY_C2, 0, "c2");
        chk("c2 rk12 const", first_key, 128'ha4970a331a78dc09c418c271e3a41d5d);
        chk("c2 rk0 const", last_key, 128'h000102030405060708090a0b0c0d0e0f);
        // back-to-back: start in the cycle right after rk0 acceptance
        run_seq(KEY_A2, 0, "a2_b2b");
        chk("a2 rk12 const", first_key, 128'he98ba06f448c773c8ecc720401002202);
        chk("a2 rk0 const", last_key, 128'h8e73b0f7da0e6452c810f32b809079e5);
        tick();
        run_seq(KEY_A2, 1, "a2_stall");
        tick();
        run_seq(KEY_C2, 2, "c2_stray_start");
        tick();
        run_seq(rand_key(), 3, "rand_rst");
        run_seq(rand_key(), 0, "rand_after_rst");
        tick();
        run_seq(rand_key(), 1, "rand_stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
